weight_update_ctrl: RTL
=======================

Name: weight_update_ctrl

Overview:
Sequencer that walks a weight memory of N_WEIGHTS entries and applies one signed delta per entry. Per entry it reads the stored weight, accepts one delta/sign pair from the training engine via a valid/ready handshake, computes a saturating add/sub and writes the result back. It sits between the backprop delta generator and the weight RAM of the drowsiness-classifier network, and owns the RAM write port during a pass.

Parameters:
W, 10, weight and delta width (unsigned magnitude)
N_WEIGHTS, 16, number of weights updated per pass
ADDR_W, 4, weight memory address width; must satisfy 2**ADDR_W >= N_WEIGHTS

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  begin a pass; sampled only in IDLE
d_valid  in  1  delta/sign pair valid
d_ready  out  1  controller accepts delta this cycle
delta  in  W  update magnitude
sign  in  1  0 = add, 1 = subtract
w_addr  out  ADDR_W  weight memory address
w_re  out  1  memory read strobe; data valid on w_rdata next cycle
w_rdata  in  W  memory read data
w_we  out  1  memory write strobe
w_wdata  out  W  write-back weight
busy  out  1  high from the cycle after start is accepted until done
done  out  1  one-cycle pulse when the last entry is written
sat_count  out  ADDR_W+1  number of saturated updates in the last or current pass

Behaviour:
- Clock and reset: single clock clk; reset rst_n is asynchronous, active-low.
- Reset: state=IDLE, index=0; all outputs 0: d_ready, w_re, w_we, busy, done, w_addr, w_wdata, sat_count.
- FSM states: IDLE, READ, LATCH, WAIT_D, WRITE, FIN.
- IDLE: if start, clear sat_count and index, go to READ. busy=0.
- READ: w_addr=index, w_re=1 for one cycle, then go to LATCH.
- LATCH: register w_rdata into a weight register, then go to WAIT_D.
- WAIT_D: d_ready=1. When d_valid is seen, register delta and sign and the ALU result, then go to WRITE. d_ready is 0 in every other state. With no d_valid the FSM stalls indefinitely, with no timeout.
- WRITE: w_we=1, w_addr=index, w_wdata=result. If the update saturated, sat_count increments. If index==N_WEIGHTS-1, go to FIN; otherwise index increments and the FSM goes to READ.
- FIN: done=1 for one cycle, busy drops in the same cycle, go to IDLE.
- Per-entry latency: 4 cycles plus the handshake wait, so a minimum of 4*N_WEIGHTS+1 cycles per pass.
- Arithmetic: computed at W+1 bits.
  - sign=0: sum = weight + delta; if the sum exceeds 2**W-1, the result is 2**W-1 and the update is flagged saturated.
  - sign=1: if delta > weight, the result is 0 and the update is flagged saturated; otherwise the result is weight - delta.
  - delta=0 writes the unchanged weight and does not count as saturated.
- Boundaries:
  - start while busy is ignored.
  - start held high in FIN has no effect; it is sampled again in IDLE on the next cycle, so back-to-back passes are allowed.
  - d_valid outside WAIT_D is not consumed; the producer holds it.
  - Reset mid-pass aborts immediately. No partial write completes after reset is asserted, and no done pulse is issued.
  - sat_count holds its value after FIN until the next start.

Decomposition:
- Shared package wu_pkg holds:
  - the state enum wu_state_t
  - the weight_t typedef (logic [W-1:0])
  - the constants W_MAX = 2**W-1 and W_MIN = 0
- One combinational sub-module, weight_update_sat (weight, delta, sign -> weight_new, sat), instanced once. The controller adds no arithmetic outside this sub-module.

Test Plan:
1. Reset mid-pass: assert rst_n=0 during WRITE of entry 3 -> w_we drops asynchronously; memory entry 3 is unchanged; busy=0, done=0; sat_count=0.
2. Subtract with no saturation: entry 0 = 860, delta = 50, sign = 1 -> write 810 to address 0; sat_count stays 0; w_we high exactly one cycle.
3. Add with no saturation: entry 1 = 624, delta = 205, sign = 0 -> write 829 to address 1.
4. Saturation at both ends: entry 2 = 1000 + 100 -> write 1023; entry 3 = 30 - 50 -> write 0. At end of pass, sat_count = 2.
5. Handshake stall: d_valid held low for 20 cycles in WAIT_D -> d_ready stays 1, no memory access occurs, and the pass resumes correctly once d_valid rises. Full 16-entry pass with zero stalls -> done asserts at cycle 65 after start.
6. start pulsed while busy -> ignored; exactly 16 writes occur and exactly one done pulse is issued.

Source files
------------

// File: rtl/wu_pkg.sv
// Shared types and constants for the weight-update sequencer.
package wu_pkg;

    // Width the saturating datapath is built for; the controller defaults to it.
    localparam int WU_W = 10;

    typedef logic [WU_W-1:0] weight_t;

    // Saturation limits of an unsigned weight.
    localparam weight_t W_MAX = weight_t'((2 ** WU_W) - 1);
    localparam weight_t W_MIN = '0;

    // Controller states, one pass visits READ/LATCH/WAIT_D/WRITE once per entry.
    typedef enum logic [2:0] {
        IDLE,
        READ,
        LATCH,
        WAIT_D,
        WRITE,
        FIN
    } wu_state_t;

endpackage

// File: rtl/weight_update_sat.sv
// Saturating add/subtract of an unsigned delta onto an unsigned weight.
// The extra top bit of the W+1 bit results is the carry (add) or borrow (sub).
module weight_update_sat
    import wu_pkg::*;
(
    input  weight_t weight,
    input  weight_t delta,
    input  logic    sign,
    output weight_t weight_new,
    output logic    sat
);

    logic [WU_W:0] sum_ext;
    logic [WU_W:0] diff_ext;

    // Clamp to W_MAX on carry out, to W_MIN on borrow; delta=0 never saturates.
    always_comb begin
        sum_ext    = {1'b0, weight} + {1'b0, delta};
        diff_ext   = {1'b0, weight} - {1'b0, delta};
        weight_new = W_MIN;
        sat        = 1'b0;
        if (!sign) begin
            if (sum_ext[WU_W]) begin
                weight_new = W_MAX;
                sat        = 1'b1;
            end else begin
                weight_new = sum_ext[WU_W-1:0];
            end
        end else begin
            if (diff_ext[WU_W]) begin
                weight_new = W_MIN;
                sat        = 1'b1;
            end else begin
                weight_new = diff_ext[WU_W-1:0];
            end
        end
    end

endmodule

// File: rtl/weight_update_ctrl.sv
// Weight-update sequencer: walks the weight RAM, reads each entry, takes one
// delta/sign pair from the delta generator, and writes back the saturated sum.
//
// Delta handshake: a transfer happens on a rising edge where d_valid and
// d_ready are both high. d_ready is high only in WAIT_D and does not depend
// on d_valid. The producer must hold delta/sign stable while d_valid is high
// and keep d_valid high until the transfer; d_valid outside WAIT_D is left
// pending. There is no timeout on the wait.
//
// All outputs are registered: they are loaded on the edge that enters the
// state they belong to, so e.g. w_we is high exactly during WRITE.
module weight_update_ctrl
    import wu_pkg::*;
#(
    parameter int W         = WU_W,
    parameter int N_WEIGHTS = 16,
    parameter int ADDR_W    = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              d_valid,
    output logic              d_ready,
    input  logic [W-1:0]      delta,
    input  logic              sign,
    output logic [ADDR_W-1:0] w_addr,
    output logic              w_re,
    input  logic [W-1:0]      w_rdata,
    output logic              w_we,
    output logic [W-1:0]      w_wdata,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   sat_count,
    output wu_state_t         dbg_state
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_WEIGHTS - 1);

    wu_state_t         state;
    logic [ADDR_W-1:0] index;
    weight_t           weight_q;
    logic              sat_q;
    weight_t           alu_new;
    logic              alu_sat;

    // The only arithmetic on weights lives in the saturating ALU.
    weight_update_sat u_sat (
        .weight     (weight_q),
        .delta      (delta),
        .sign       (sign),
        .weight_new (alu_new),
        .sat        (alu_sat)
    );

    // Expose the FSM state for checkers and debug.
    assign dbg_state = state;

    // Main sequencer; reset aborts a pass immediately with no write or done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            index     <= '0;
            weight_q  <= '0;
            sat_q     <= 1'b0;
            d_ready   <= 1'b0;
            w_re      <= 1'b0;
            w_we      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            w_addr    <= '0;
            w_wdata   <= '0;
            sat_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        sat_count <= '0;
                        index     <= '0;
                        w_addr    <= '0;
                        w_re      <= 1'b1;
                        busy      <= 1'b1;
                        state     <= READ;
                    end
                end
                READ: begin
                    // Read data appears on w_rdata during LATCH.
                    w_re  <= 1'b0;
                    state <= LATCH;
                end
                LATCH: begin
                    weight_q <= w_rdata;
                    d_ready  <= 1'b1;
                    state    <= WAIT_D;
                end
                WAIT_D: begin
                    if (d_valid) begin
                        d_ready <= 1'b0;
                        w_wdata <= alu_new;
                        sat_q   <= alu_sat;
                        w_we    <= 1'b1;
                        w_addr  <= index;
                        state   <= WRITE;
                    end
                end
                WRITE: begin
                    w_we <= 1'b0;
                    if (sat_q) begin
                        sat_count <= sat_count + 1'b1;
                    end
                    if (index == LAST_IDX) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= FIN;
                    end else begin
                        index  <= index + 1'b1;
                        w_addr <= index + 1'b1;
                        w_re   <= 1'b1;
                        state  <= READ;
                    end
                end
                FIN: begin
                    // start is ignored here; IDLE samples it next cycle.
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
